// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte-enabled data-memory access with load extension and fault detection
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, sdata_q, sdata_d, load_data_q, load_data_d;
  logic [2:0] f3_q, f3_d;
  logic st_q, st_d, fault_q, fault_d;
  logic legal, acc;
  logic [WIDTH-1:0] sh, ext, wd;
  logic [3:0] be;
  always_comb begin
    legal = (is_store ? funct3 <= 3'd2 : (funct3 != 3'd3 && funct3 <= 3'd5))
            && !(funct3[1:0] == 2'd1 && addr[0])
            && !(funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
    sh = mem_rdata >> {addr_q[1:0], 3'b000};
    ext = f3_q[1:0] == 2'd0 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
          f3_q[1:0] == 2'd1 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : sh;
    be = (!st_q || f3_q[1:0] == 2'd2) ? 4'hf :
         f3_q[1:0] == 2'd0 ? 4'b0001 << addr_q[1:0] :
         addr_q[1] ? 4'b1100 : 4'b0011;
    wd = f3_q[1:0] == 2'd0 ? {4{sdata_q[7:0]}} :
         f3_q[1:0] == 2'd1 ? {2{sdata_q[15:0]}} : sdata_q;
    state_d = state_q;
    addr_d = addr_q;
    sdata_d = sdata_q;
    f3_d = f3_q;
    st_d = st_q;
    fault_d = fault_q;
    load_data_d = load_data_q;
    if (state_q == IDLE && start) begin
      addr_d = addr;
      sdata_d = store_data;
      f3_d = funct3;
      st_d = is_store;
      state_d = legal ? ACCESS : DONE;
      fault_d = legal ? fault_q : 1'b1;
      load_data_d = legal ? load_data_q : '0;
    end else if (state_q == ACCESS && mem_ack) begin
      state_d = DONE;
      fault_d = 1'b0;
      load_data_d = st_q ? '0 : ext;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      sdata_q <= '0;
      f3_q <= '0;
      st_q <= 1'b0;
      fault_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      sdata_q <= sdata_d;
      f3_q <= f3_d;
      st_q <= st_d;
      fault_q <= fault_d;
      load_data_q <= load_data_d;
    end
  end
  // memory port is quiet outside ACCESS so reset and faults show all-zero
  assign acc = state_q == ACCESS;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign fault = fault_q;
  assign load_data = load_data_q;
  assign mem_req = acc;
  assign mem_we = acc & st_q;
  assign mem_addr = acc ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign mem_be = acc ? be : 4'h0;
  assign mem_wdata = acc ? wd : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized accesses checked every cycle against a timeline/transaction model
module tb_load_store_unit;
  logic clk = 0, rst = 1, start = 0, is_store = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  int n_acc = 0, n_flt = 0, n_req = 0, n_done = 0;
  logic req_prev = 0;
  logic e_busy = 0, e_done = 0, e_req = 0, e_we = 0, e_fault = 0;
  logic [31:0] e_ld = 0, e_addr = 0, e_wd = 0;
  logic [3:0] e_be = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done), .fault(fault),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(bit st, logic [2:0] f, logic [31:0] a);
    int sz = int'(f[1:0]);
    if (st ? f > 3'd2 : !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (a % (32'd1 << sz)) == 0;
  endfunction

  function automatic logic [31:0] ext(logic [2:0] f, logic [31:0] a, logic [31:0] rd);
    longint w = longint'(rd) >> (8 * int'(a[1:0]));
    int nb = f[1:0] == 2'd0 ? 8 : f[1:0] == 2'd1 ? 16 : 32;
    longint v = w % (longint'(1) << nb);
    if (!f[2] && nb < 32 && v >= (longint'(1) << (nb - 1))) v -= longint'(1) << nb;
    return v[31:0];
  endfunction

  function automatic logic [3:0] be_of(bit st, logic [2:0] f, logic [31:0] a);
    if (!st || f == 3'd2) return 4'hf;
    return f == 3'd0 ? 4'(1 << a[1:0]) : 4'(3 << a[1:0]);
  endfunction

  function automatic logic [31:0] wd_of(logic [2:0] f, logic [31:0] d);
    return f == 3'd0 ? {24'd0, d[7:0]} * 32'h01010101 :
           f == 3'd1 ? {16'd0, d[15:0]} * 32'h00010001 : d;
  endfunction

  // expectations are set at negedge for the state following the next posedge
  task automatic access(bit st, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                        logic [31:0] rd, int dly, bit poke);
    bit ok = legal(st, f, a);
    @(negedge clk);
    start = 1; is_store = st; funct3 = f; addr = a; store_data = d; mem_ack = 0;
    n_acc++;
    e_busy = 1;
    if (!ok) begin
      e_done = 1; e_fault = 1; e_ld = 0; n_flt++;
    end else begin
      e_req = 1; e_we = st; e_addr = {a[31:2], 2'b00}; e_be = be_of(st, f, a); e_wd = wd_of(f, d);
    end
    if (ok) for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      start = poke; is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; store_data = $urandom;
      mem_ack = (i == dly);
      mem_rdata = (i == dly) ? rd : $urandom;
      if (i == dly) begin
        e_req = 0; e_done = 1; e_fault = 0; e_ld = st ? 32'd0 : ext(f, a, rd);
      end
    end
    @(negedge clk);
    start = poke; mem_ack = 0; e_busy = 0; e_done = 0;
    @(negedge clk);
    start = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      mem_ack = 1'($urandom); mem_rdata = $urandom;
    end
    @(negedge clk);
    mem_ack = 0;
  endtask

  always @(posedge clk) begin
    #2;
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mem_req", mem_req, e_req);
    chk("fault", fault, e_fault);
    chk("load_data", load_data, e_ld);
    if (e_req) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_be", mem_be, e_be);
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);
    end
    if (mem_req && !req_prev) n_req++;
    req_prev = mem_req;
    if (done) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    chk("pin_lw", ext(3'd2, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    chk("pin_lb", ext(3'd0, 32'h103, 32'h80112233), 32'hFFFFFF80);
    chk("pin_lbu", ext(3'd4, 32'h103, 32'h80112233), 32'h00000080);
    chk("pin_lh", ext(3'd1, 32'h102, 32'h80112233), 32'hFFFF8011);
    chk("pin_sb_be", be_of(1, 3'd0, 32'h201), 32'h2);
    chk("pin_sh_be", be_of(1, 3'd1, 32'h202), 32'hC);
    chk("pin_sb_wd", wd_of(3'd0, 32'hA5), 32'hA5A5A5A5);
    chk("pin_lw_mis", legal(0, 3'd2, 32'h102), 0);
    chk("pin_f3_011", legal(0, 3'd3, 32'h100), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    @(negedge clk);
    rst = 0;
    access(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0);
    access(0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 0);
    access(0, 3'd4, 32'h103, 32'h0, 32'h80112233, 1, 0);
    access(0, 3'd1, 32'h102, 32'h0, 32'h80112233, 0, 0);
    access(1, 3'd0, 32'h201, 32'hA5, 32'h0, 0, 0);
    access(1, 3'd1, 32'h202, 32'h1234, 32'h0, 1, 1);
    access(0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1);
    access(1, 3'd1, 32'h203, 32'h0, 32'h0, 0, 1);
    access(0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1);
    idle(3);
    // abort an access with reset; the late ack must be ignored
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'd2; addr = 32'h300;
    e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h300; e_be = 4'hf;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    e_busy = 0; e_req = 0; e_done = 0; e_fault = 0; e_ld = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_abort_addr", mem_addr, 0);
    chk("rst_abort_be", mem_be, 0);
    chk("rst_abort_load", load_data, 0);
    @(negedge clk);
    rst = 0; mem_ack = 1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 0;
    access(0, 3'd5, 32'h402, 32'h0, 32'h9ABCDEF0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);
    chk("req_count", n_req, n_acc - n_flt + 1);
    chk("done_count", n_done, n_acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
